multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the MIPS-subset datapath: add, sub, ori, lw, sw, beq, lui, jal, jr. It replaces the single-cycle decode with a state machine that drives the existing NPC, ALU, EXT, GRF and unified memory over several cycles per instruction. Memory is shared between instruction fetch and data access through a req/ready handshake. The block sits between the IR/ALU flags and every datapath control strobe.

---
 rtl/multicycle_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// ----------------
// Multi-cycle sequencer for the MIPS-subset datapath (add, sub, ori, lw, sw,
// beq, lui, jal, jr). It steps each instruction through FETCH, DECODE, EXEC,
// MEM and WB and drives the NPC, ALU, EXT, GRF and unified-memory strobes.
// Instruction fetch and data access share one memory through a req/ready
// handshake.
//
// Build option:
//   MC_CTRL_TIMEOUT_EN - when defined, a wait counter sends the block to TRAP
//                        once a FETCH or MEM request has waited MEM_WAIT_MAX
//                        cycles and ready is still low. When undefined, memory
//                        waits are unbounded and MEM_WAIT_MAX has no effect.
//
// Ports:
//   clk        - system clock, rising edge
//   reset_n    - asynchronous active-low reset; forces every output to 0
//   Instr      - IR contents (opcode [31:26], funct [5:0])
//   Zero       - ALU equality flag, used by beq in EXEC
//   mem_ready  - memory completes the current request this cycle
//   MemReq     - memory request
//   MemWe      - memory write enable, qualified by MemReq
//   IorD       - memory address select: 0 = PC, 1 = ALU result
//   IRWrite    - latch memory data into IR
//   PCWrite    - update PC from NPC
//   opNPC      - 000 PC+4, 001 branch, 010 jal target, 011 jr
//   opALU      - 000 add, 001 sub, 010 or, 011 lui
//   ALUsrc     - 1 = extended immediate is ALU operand B
//   opEXT      - 1 = sign-extend, 0 = zero-extend
//   RegWrite   - GRF write enable
//   RegSel     - 1 = rd destination, 0 = rt destination
//   isJAL      - write PC to $31
//   MemToReg   - GRF write data from memory data register
//   instr_done - one-cycle retirement pulse
//   trap       - sticky halt indicator
//   state      - current state, for debug

module multicycle_ctrl #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] Instr,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        MemReq,
    output logic        MemWe,
    output logic        IorD,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic [2:0]  opNPC,
    output logic [2:0]  opALU,
    output logic        ALUsrc,
    output logic        opEXT,
    output logic        RegWrite,
    output logic        RegSel,
    output logic        isJAL,
    output logic        MemToReg,
    output logic        instr_done,
    output logic        trap,
    output logic [2:0]  state
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd7
    } CtrlState;

    typedef enum logic [3:0] {
        CLS_ADD,
        CLS_SUB,
        CLS_ORI,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_LUI,
        CLS_JAL,
        CLS_JR,
        CLS_ILLEGAL
    } InstrClass;

    CtrlState  curState;
    CtrlState  nextState;
    InstrClass instrClass;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [2:0] aluOpSel;
    logic       aluSrcSel;
    logic       extSel;
    logic       waitLimit;
    logic       unusedInstrBits;

    assign opcode = Instr[31:26];
    assign funct  = Instr[5:0];

    // Register and immediate fields only matter to the datapath.
    assign unusedInstrBits = ^Instr[25:6];

`ifdef MC_CTRL_TIMEOUT_EN
    localparam int CW = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);

    logic [CW-1:0] waitCount;

    // Counts consecutive not-ready cycles of the current FETCH/MEM request.
    // It is zero whenever the block is outside those states, so every new
    // request starts counting from 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            waitCount <= '0;
        end else if ((curState == FETCH || curState == MEM) && !mem_ready &&
                     nextState == curState) begin
            waitCount <= waitCount + CW'(1);
        end else begin
            waitCount <= '0;
        end
    end

    assign waitLimit = (waitCount == CW'(MEM_WAIT_MAX));
`else
    // Without the timeout the limit is never reached and the parameter is
    // only kept so both builds share one interface.
    localparam int unusedWaitMax = MEM_WAIT_MAX;

    assign waitLimit = 1'b0;
`endif

    // Instruction classification; R-type is legal only for add, sub and jr.
    always_comb begin
        instrClass = CLS_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  instrClass = CLS_ADD;
                    FN_SUB:  instrClass = CLS_SUB;
                    FN_JR:   instrClass = CLS_JR;
                    default: instrClass = CLS_ILLEGAL;
                endcase
            end
            OP_ORI:  instrClass = CLS_ORI;
            OP_LW:   instrClass = CLS_LW;
            OP_SW:   instrClass = CLS_SW;
            OP_BEQ:  instrClass = CLS_BEQ;
            OP_LUI:  instrClass = CLS_LUI;
            OP_JAL:  instrClass = CLS_JAL;
            default: instrClass = CLS_ILLEGAL;
        endcase
    end

    // ALU/EXT setup per instruction. It is driven in EXEC and kept through
    // MEM and WB so the ALU result stays valid for the address and the
    // register write-back without an ALUOut register.
    always_comb begin
        aluOpSel  = 3'b000;
        aluSrcSel = 1'b0;
        extSel    = 1'b0;
        case (instrClass)
            CLS_SUB: aluOpSel = 3'b001;
            CLS_ORI: begin
                aluOpSel  = 3'b010;
                aluSrcSel = 1'b1;
            end
            CLS_LUI: begin
                aluOpSel  = 3'b011;
                aluSrcSel = 1'b1;
            end
            CLS_LW, CLS_SW: begin
                aluSrcSel = 1'b1;
                extSel    = 1'b1;
            end
            CLS_BEQ: begin
                aluOpSel = 3'b001;
                extSel   = 1'b1;
            end
            default: aluOpSel = 3'b000;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            curState <= FETCH;
        end else begin
            curState <= nextState;
        end
    end

    // Next state and strobes. Everything is gated by reset_n so the outputs
    // read 0 for as long as reset is held, including the FETCH request.
    always_comb begin
        nextState  = curState;
        MemReq     = 1'b0;
        MemWe      = 1'b0;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        opNPC      = 3'b000;
        opALU      = 3'b000;
        ALUsrc     = 1'b0;
        opEXT      = 1'b0;
        RegWrite   = 1'b0;
        RegSel     = 1'b0;
        isJAL      = 1'b0;
        MemToReg   = 1'b0;
        instr_done = 1'b0;
        trap       = 1'b0;
        state      = 3'b000;

        if (reset_n) begin
            state = curState;
            case (curState)
                FETCH: begin
                    MemReq = 1'b1;
                    if (mem_ready) begin
                        IRWrite   = 1'b1;
                        PCWrite   = 1'b1;
                        nextState = DECODE;
                    end else if (waitLimit) begin
                        nextState = TRAP;
                    end
                end

                // PC already holds old PC+4 here, which is what jal links.
                DECODE: begin
                    case (instrClass)
                        CLS_JAL: begin
                            PCWrite    = 1'b1;
                            opNPC      = 3'b010;
                            RegWrite   = 1'b1;
                            isJAL      = 1'b1;
                            instr_done = 1'b1;
                            nextState  = FETCH;
                        end
                        CLS_JR: begin
                            PCWrite    = 1'b1;
                            opNPC      = 3'b011;
                            instr_done = 1'b1;
                            nextState  = FETCH;
                        end
                        CLS_ILLEGAL: nextState = TRAP;
                        default:     nextState = EXEC;
                    endcase
                end

                EXEC: begin
                    opALU  = aluOpSel;
                    ALUsrc = aluSrcSel;
                    opEXT  = extSel;
                    case (instrClass)
                        CLS_ADD, CLS_SUB, CLS_ORI, CLS_LUI: nextState = WB;
                        CLS_LW, CLS_SW:                     nextState = MEM;
                        CLS_BEQ: begin
                            PCWrite    = Zero;
                            opNPC      = 3'b001;
                            instr_done = 1'b1;
                            nextState  = FETCH;
                        end
                        default: nextState = TRAP;
                    endcase
                end

                MEM: begin
                    opALU  = aluOpSel;
                    ALUsrc = aluSrcSel;
                    opEXT  = extSel;
                    MemReq = 1'b1;
                    IorD   = 1'b1;
                    MemWe  = (instrClass == CLS_SW);
                    if (mem_ready) begin
                        if (instrClass == CLS_SW) begin
                            instr_done = 1'b1;
                            nextState  = FETCH;
                        end else if (instrClass == CLS_LW) begin
                            nextState = WB;
                        end else begin
                            nextState = TRAP;
                        end
                    end else if (waitLimit) begin
                        nextState = TRAP;
                    end
                end

                WB: begin
                    opALU      = aluOpSel;
                    ALUsrc     = aluSrcSel;
                    opEXT      = extSel;
                    RegWrite   = 1'b1;
                    RegSel     = (instrClass == CLS_ADD) || (instrClass == CLS_SUB);
                    MemToReg   = (instrClass == CLS_LW);
                    instr_done = 1'b1;
                    nextState  = FETCH;
                end

                TRAP: begin
                    trap = 1'b1;
                end

                default: nextState = TRAP;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
// ------------------
// Self-checking bench for multicycle_ctrl. For each instruction a reference
// model expands the instruction kind, the number of memory wait cycles and
// the Zero flag into the expected per-cycle sequence of state and strobes;
// the bench then drives mem_ready/Zero cycle by cycle and compares.

module tb_multicycle_ctrl;

    localparam int MAXW = 15;
`ifdef MC_CTRL_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic [31:0] Instr;
    logic        Zero;
    logic        mem_ready;
    logic        MemReq, MemWe, IorD, IRWrite, PCWrite;
    logic [2:0]  opNPC, opALU;
    logic        ALUsrc, opEXT, RegWrite, RegSel, isJAL, MemToReg;
    logic        instr_done, trap;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] st;
        logic       memReq;
        logic       memWe;
        logic       iorD;
        logic       irWrite;
        logic       pcWrite;
        logic [2:0] opNPC;
        logic [2:0] opALU;
        logic       aluSrc;
        logic       opEXT;
        logic       regWrite;
        logic       regSel;
        logic       isJAL;
        logic       memToReg;
        logic       instrDone;
        logic       trap;
    } Obs;

    typedef struct {
        logic ready;
        logic zero;
        Obs   o;
    } Step;

    typedef enum {K_ADD, K_SUB, K_ORI, K_LW, K_SW, K_BEQ, K_LUI, K_JAL, K_JR,
                  K_BAD, K_BADFN} Kind;

    Step trace[$];
    Obs  actual;

    assign actual = {state, MemReq, MemWe, IorD, IRWrite, PCWrite, opNPC, opALU,
                     ALUsrc, opEXT, RegWrite, RegSel, isJAL, MemToReg,
                     instr_done, trap};

    multicycle_ctrl #(.MEM_WAIT_MAX(MAXW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Instr      (Instr),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .MemReq     (MemReq),
        .MemWe      (MemWe),
        .IorD       (IorD),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .opNPC      (opNPC),
        .opALU      (opALU),
        .ALUsrc     (ALUsrc),
        .opEXT      (opEXT),
        .RegWrite   (RegWrite),
        .RegSel     (RegSel),
        .isJAL      (isJAL),
        .MemToReg   (MemToReg),
        .instr_done (instr_done),
        .trap       (trap),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Builds a random instruction word of the given kind.
    function automatic logic [31:0] encode(input Kind k);
        logic [31:0] r;
        r = $urandom;
        case (k)
            K_ADD:   return {6'h00, r[25:6], 6'h20};
            K_SUB:   return {6'h00, r[25:6], 6'h22};
            K_JR:    return {6'h00, r[25:6], 6'h08};
            K_BADFN: return {6'h00, r[25:6], 6'h25};
            K_ORI:   return {6'h0D, r[25:0]};
            K_LW:    return {6'h23, r[25:0]};
            K_SW:    return {6'h2B, r[25:0]};
            K_BEQ:   return {6'h04, r[25:0]};
            K_LUI:   return {6'h0F, r[25:0]};
            K_JAL:   return {6'h03, r[25:0]};
            default: return {6'h3F, r[25:0]};
        endcase
    endfunction

    function automatic Obs blank(input logic [2:0] st);
        Obs o;
        o = '0;
        o.st = st;
        return o;
    endfunction

    // ALU operation, operand-B source and extension mode of each instruction.
    function automatic Obs withAlu(input Obs oIn, input Kind k);
        Obs o;
        o = oIn;
        case (k)
            K_SUB: o.opALU = 3'd1;
            K_ORI: begin o.opALU = 3'd2; o.aluSrc = 1'b1; end
            K_LUI: begin o.opALU = 3'd3; o.aluSrc = 1'b1; end
            K_LW, K_SW: begin o.aluSrc = 1'b1; o.opEXT = 1'b1; end
            K_BEQ: begin o.opALU = 3'd1; o.opEXT = 1'b1; end
            default: o.opALU = 3'd0;
        endcase
        return o;
    endfunction

    function automatic int baseCpi(input Kind k);
        case (k)
            K_JAL, K_JR: return 2;
            K_BEQ:       return 3;
            K_LW:        return 5;
            default:     return 4;
        endcase
    endfunction

    task automatic pushStep(input logic rdy, input Obs o);
        Step s;
        s.ready = rdy;
        s.zero  = 1'($urandom);
        s.o     = o;
        trace.push_back(s);
    endtask

    task automatic pushTrap(input int n);
        Obs o;
        for (int i = 0; i < n; i++) begin
            o = blank(3'd7);
            o.trap = 1'b1;
            pushStep(1'($urandom), o);
        end
    endtask

    // Reference model: expected cycle sequence for one instruction.
    task automatic buildTrace(input Kind k, input int fw, input int mw,
                              input logic z, input int trapCycles);
        Obs  o;
        Step s;
        bit  timedOut;
        int  nWait;
        trace.delete();

        timedOut = TIMEOUT_ON && (fw > MAXW);
        nWait = timedOut ? MAXW + 1 : fw;
        for (int i = 0; i < nWait; i++) begin
            o = blank(3'd0);
            o.memReq = 1'b1;
            pushStep(1'b0, o);
        end
        if (timedOut) begin
            pushTrap(trapCycles);
            return;
        end
        o = blank(3'd0);
        o.memReq = 1'b1;
        o.irWrite = 1'b1;
        o.pcWrite = 1'b1;
        pushStep(1'b1, o);

        o = blank(3'd1);
        if (k == K_JAL) begin
            o.pcWrite = 1'b1; o.opNPC = 3'd2; o.regWrite = 1'b1;
            o.isJAL = 1'b1; o.instrDone = 1'b1;
            pushStep(1'($urandom), o);
            return;
        end
        if (k == K_JR) begin
            o.pcWrite = 1'b1; o.opNPC = 3'd3; o.instrDone = 1'b1;
            pushStep(1'($urandom), o);
            return;
        end
        pushStep(1'($urandom), o);
        if (k == K_BAD || k == K_BADFN) begin
            pushTrap(trapCycles);
            return;
        end

        o = withAlu(blank(3'd2), k);
        if (k == K_BEQ) begin
            o.pcWrite = z; o.opNPC = 3'd1; o.instrDone = 1'b1;
            s.ready = 1'($urandom);
            s.zero  = z;
            s.o     = o;
            trace.push_back(s);
            return;
        end
        pushStep(1'($urandom), o);

        if (k == K_LW || k == K_SW) begin
            timedOut = TIMEOUT_ON && (mw > MAXW);
            nWait = timedOut ? MAXW + 1 : mw;
            o = withAlu(blank(3'd3), k);
            o.memReq = 1'b1;
            o.iorD   = 1'b1;
            o.memWe  = (k == K_SW);
            for (int i = 0; i < nWait; i++) pushStep(1'b0, o);
            if (timedOut) begin
                pushTrap(trapCycles);
                return;
            end
            if (k == K_SW) begin
                o.instrDone = 1'b1;
                pushStep(1'b1, o);
                return;
            end
            pushStep(1'b1, o);
        end

        o = withAlu(blank(3'd4), k);
        o.regWrite  = 1'b1;
        o.regSel    = (k == K_ADD || k == K_SUB);
        o.memToReg  = (k == K_LW);
        o.instrDone = 1'b1;
        pushStep(1'($urandom), o);
    endtask

    // Runs one instruction (or its first stopAfter cycles) and checks every
    // cycle, then checks the retirement cycle against the CPI rule.
    task automatic runInstr(input string name, input Kind k, input int fw,
                            input int mw, input logic z, input int trapCycles,
                            input int stopAfter);
        int n;
        int doneAt;
        int cpi;
        buildTrace(k, fw, mw, z, trapCycles);
        Instr = encode(k);
        n = trace.size();
        if (stopAfter >= 0 && stopAfter < n) n = stopAfter;
        doneAt = -1;
        for (int i = 0; i < n; i++) begin
            mem_ready = trace[i].ready;
            Zero      = trace[i].zero;
            #1;
            checks++;
            if (actual !== trace[i].o) begin
                errors++;
                $display("[TB] FAIL %s cycle %0d: got %h, expected %h",
                         name, i, actual, trace[i].o);
            end
            if (doneAt < 0 && instr_done === 1'b1) doneAt = i + 1;
            @(negedge clk);
        end
        if (stopAfter < 0 && trapCycles == 0) begin
            cpi = baseCpi(k) + fw + ((k == K_LW || k == K_SW) ? mw : 0);
            checks++;
            if (doneAt !== cpi) begin
                errors++;
                $display("[TB] FAIL %s cpi: got %0d, expected %0d", name, doneAt, cpi);
            end
        end
    endtask

    // Holds reset for two cycles, checking that every output is 0.
    task automatic doReset();
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_ready = 1'($urandom);
            Zero      = 1'($urandom);
            #1;
            checks++;
            if (actual !== '0) begin
                errors++;
                $display("[TB] FAIL reset outputs: got %h, expected 0", actual);
            end
            @(negedge clk);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        doReset();
    endtask

    task automatic test_ori();
        Step s;
        runInstr("ori", K_ORI, 0, 0, 1'b0, 0, -1);
        // Same instruction with the literal ori $1,$0,0x1234 word.
        buildTrace(K_ORI, 0, 0, 1'b0, 0);
        Instr = {6'h0D, 5'd0, 5'd1, 16'h1234};
        for (int i = 0; i < trace.size(); i++) begin
            s = trace[i];
            mem_ready = 1'b1;
            Zero = s.zero;
            #1;
            checks++;
            if (actual !== s.o) begin
                errors++;
                $display("[TB] FAIL ori_1234 cycle %0d: got %h, expected %h", i, actual, s.o);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lw_wait();
        runInstr("lw_mem_wait3", K_LW, 0, 3, 1'b0, 0, -1);
        runInstr("sw_mem_wait2", K_SW, 1, 2, 1'b0, 0, -1);
    endtask

    task automatic test_beq();
        runInstr("beq_taken", K_BEQ, 0, 0, 1'b1, 0, -1);
        runInstr("beq_not_taken", K_BEQ, 0, 0, 1'b0, 0, -1);
    endtask

    task automatic test_jal_jr();
        runInstr("jal", K_JAL, 0, 0, 1'b0, 0, -1);
        runInstr("jr", K_JR, 0, 0, 1'b0, 0, -1);
    endtask

    task automatic test_back_to_back();
        Kind k;
        for (int i = 0; i < 25; i++) begin
            k = Kind'($urandom_range(0, 8));
            runInstr($sformatf("rand%0d_%s", i, k.name()), k,
                     $urandom_range(0, 3), $urandom_range(0, 3),
                     1'($urandom), 0, -1);
        end
    endtask

    task automatic test_illegal();
        runInstr("illegal_opcode", K_BAD, 0, 0, 1'b0, 20, -1);
        doReset();
        runInstr("after_trap", K_ADD, 0, 0, 1'b0, 0, -1);
        runInstr("illegal_funct", K_BADFN, 1, 0, 1'b0, 5, -1);
        doReset();
    endtask

    task automatic test_reset_midway();
        runInstr("lw_abort_exec", K_LW, 2, 0, 1'b0, 0, 4);
        doReset();
        runInstr("lw_after_abort", K_LW, 0, 1, 1'b0, 0, -1);
        runInstr("ori_abort_fetch", K_ORI, 12, 0, 1'b0, 0, 8);
        doReset();
        runInstr("ori_after_abort", K_ORI, MAXW, 0, 1'b0, 0, -1);
    endtask

    task automatic test_wait_limit();
        runInstr("fetch_ready_at_limit", K_ADD, MAXW, 0, 1'b0, 0, -1);
        runInstr("mem_ready_at_limit", K_SW, 0, MAXW, 1'b0, 0, -1);
`ifdef MC_CTRL_TIMEOUT_EN
        runInstr("fetch_timeout", K_ORI, MAXW + 1, 0, 1'b0, 6, -1);
        doReset();
        runInstr("mem_timeout", K_LW, 0, MAXW + 1, 1'b0, 6, -1);
        doReset();
`else
        runInstr("fetch_long_wait", K_ORI, 40, 0, 1'b0, 0, -1);
        runInstr("mem_long_wait", K_LW, 0, 40, 1'b0, 0, -1);
`endif
    endtask

    initial begin
        reset_n   = 1'b0;
        Instr     = '0;
        Zero      = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_ori();
        test_lw_wait();
        test_beq();
        test_jal_jr();
        test_back_to_back();
        test_illegal();
        test_reset_midway();
        test_wait_limit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
